// File: rtl/gas_station_pkg.sv
// Shared types for the fuel-pump scheduler: FSM encoding and default widths.
package gas_station_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    ARMED      = 2'b01,
    DELIVERING = 2'b10,
    CLOSE      = 2'b11
  } pump_state_t;

  localparam int UNITS_W_DEF = 8;

endpackage

// File: rtl/pump_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from i_ptr+1, wrapping.
module rr_arbiter #(
  parameter int LANES = 4,
  parameter int PTR_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [LANES-1:0] o_grant,
  output logic             o_valid
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= LANES; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % LANES);
      if (!o_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pump_scheduler.sv
// Shares one pump among LANES lanes: round-robin grant, payment wait, metered delivery.
// Optional ARMED-state payment timeout enabled by defining PUMP_SCHED_TIMEOUT_EN.
module pump_scheduler
  import gas_station_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int UNITS_W = UNITS_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LANES-1:0]   REQ,
  input  logic               START,
  input  logic [UNITS_W-1:0] UNITS,
  input  logic               FLOW_TICK,
  input  logic               TANKFULL,
  input  logic               EMERGENCY_STOP,
  output logic [1:0]         state,
  output logic [LANES-1:0]   GRANT,
  output logic               DELIVERGAS,
  output logic               DONE,
  output logic [UNITS_W-1:0] DELIVERED
);

  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

  pump_state_t        r_state, w_state_next;
  logic [PTR_W-1:0]   r_ptr, w_ptr_next;
  logic [PTR_W-1:0]   r_lane, w_lane_next;
  logic [LANES-1:0]   r_grant, w_grant_next;
  logic               r_gas, w_gas_next;
  logic               r_done, w_done_next;
  logic [UNITS_W-1:0] r_delivered, w_delivered_next;
  logic [UNITS_W-1:0] r_limit, w_limit_next;

  logic [LANES-1:0]   w_win;
  logic               w_win_valid;
  logic [PTR_W-1:0]   w_win_idx;
  logic               w_req_held;
  logic               w_tick_ok;
  logic [UNITS_W-1:0] w_cnt;

`ifdef PUMP_SCHED_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] r_timer, w_timer_next;
`endif

  rr_arbiter #(.LANES(LANES), .PTR_W(PTR_W)) u_arb (
    .i_req   (REQ),
    .i_ptr   (r_ptr),
    .o_grant (w_win),
    .o_valid (w_win_valid)
  );

  always_comb begin
    w_win_idx = '0;
    for (int k = 0; k < LANES; k++) begin
      if (w_win[k]) w_win_idx = PTR_W'(k);
    end
  end

  assign w_req_held = REQ[r_lane];
  // Ticks past the limit are dropped so the count can never wrap.
  assign w_tick_ok  = FLOW_TICK && (r_delivered < r_limit);
  assign w_cnt      = r_delivered + UNITS_W'(w_tick_ok);

  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_lane_next      = r_lane;
    w_grant_next     = r_grant;
    w_gas_next       = r_gas;
    w_done_next      = 1'b0;
    w_delivered_next = r_delivered;
    w_limit_next     = r_limit;
`ifdef PUMP_SCHED_TIMEOUT_EN
    w_timer_next     = '0;
`endif
    case (r_state)
      IDLE: begin
        if (w_win_valid && !EMERGENCY_STOP) begin
          w_grant_next = w_win;
          w_lane_next  = w_win_idx;
          w_state_next = ARMED;
        end
      end
      ARMED: begin
        if (!w_req_held) begin
          w_grant_next = '0;
          w_ptr_next   = r_lane;
          w_state_next = IDLE;
        end else if (START && !EMERGENCY_STOP) begin
          w_limit_next     = UNITS;
          w_delivered_next = '0;
          if (UNITS == '0) begin
            w_state_next = CLOSE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = DELIVERING;
            w_gas_next   = 1'b1;
          end
        end
`ifdef PUMP_SCHED_TIMEOUT_EN
        else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
          w_delivered_next = '0;
          w_state_next     = CLOSE;
          w_done_next      = 1'b1;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
`endif
      end
      DELIVERING: begin
        w_delivered_next = w_cnt;
        if ((w_cnt == r_limit) || TANKFULL || EMERGENCY_STOP || !w_req_held) begin
          w_gas_next   = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = CLOSE;
        end
      end
      CLOSE: begin
        w_grant_next = '0;
        w_ptr_next   = r_lane;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= PTR_W'(LANES - 1);
      r_lane      <= '0;
      r_grant     <= '0;
      r_gas       <= 1'b0;
      r_done      <= 1'b0;
      r_delivered <= '0;
      r_limit     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_lane      <= w_lane_next;
      r_grant     <= w_grant_next;
      r_gas       <= w_gas_next;
      r_done      <= w_done_next;
      r_delivered <= w_delivered_next;
      r_limit     <= w_limit_next;
    end
  end

`ifdef PUMP_SCHED_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_timer <= '0;
    else       r_timer <= w_timer_next;
  end
`endif

  assign state      = r_state;
  assign GRANT      = r_grant;
  assign DELIVERGAS = r_gas;
  assign DONE       = r_done;
  assign DELIVERED  = r_delivered;

endmodule

// File: tb/tb_pump_scheduler.sv
// Directed self-checking bench for pump_scheduler; expectations are hand-computed.
module tb_pump_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] REQ;
  logic       START;
  logic [7:0] UNITS;
  logic       FLOW_TICK;
  logic       TANKFULL;
  logic       EMERGENCY_STOP;
  logic [1:0] state;
  logic [3:0] GRANT;
  logic       DELIVERGAS;
  logic       DONE;
  logic [7:0] DELIVERED;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  pump_scheduler #(.LANES(4), .UNITS_W(8), .TIMEOUT(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .REQ            (REQ),
    .START          (START),
    .UNITS          (UNITS),
    .FLOW_TICK      (FLOW_TICK),
    .TANKFULL       (TANKFULL),
    .EMERGENCY_STOP (EMERGENCY_STOP),
    .state          (state),
    .GRANT          (GRANT),
    .DELIVERGAS     (DELIVERGAS),
    .DONE           (DONE),
    .DELIVERED      (DELIVERED)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    REQ = '0; START = 0; UNITS = '0; FLOW_TICK = 0; TANKFULL = 0; EMERGENCY_STOP = 0;
    do_reset();
    check("rst_state", 32'(state), 32'h0);
    check("rst_grant", 32'(GRANT), 32'h0);
    check("rst_gas",   32'(DELIVERGAS), 32'h0);
    check("rst_done",  32'(DONE), 32'h0);
    check("rst_deliv", 32'(DELIVERED), 32'h0);

    // Basic session on lane 1, three units
    REQ = 4'b0010;
    step();
    check("t1_grant", 32'(GRANT), 32'h2);
    check("t1_armed", 32'(state), 32'h1);
    START = 1; UNITS = 8'd3;
    step();
    START = 0;
    check("t1_gas_on", 32'(DELIVERGAS), 32'h1);
    check("t1_deliv0", 32'(DELIVERED), 32'h0);
    FLOW_TICK = 1;
    step();
    check("t1_cnt1", 32'(DELIVERED), 32'h1);
    check("t1_gas1", 32'(DELIVERGAS), 32'h1);
    step();
    check("t1_cnt2", 32'(DELIVERED), 32'h2);
    step();
    check("t1_cnt3", 32'(DELIVERED), 32'h3);
    check("t1_gas_off", 32'(DELIVERGAS), 32'h0);
    check("t1_close", 32'(state), 32'h3);
    check("t1_done", 32'(DONE), 32'h1);
    check("t1_grant_hold", 32'(GRANT), 32'h2);
    REQ = '0;
    step();
    FLOW_TICK = 0;
    check("t1_idle", 32'(state), 32'h0);
    check("t1_done_pulse", 32'(DONE), 32'h0);
    check("t1_grant_clr", 32'(GRANT), 32'h0);
    check("t1_deliv_hold", 32'(DELIVERED), 32'h3);

    // Fairness with all lanes requesting
    do_reset();
    REQ = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      step();
      check($sformatf("t2_grant%0d", s), 32'(GRANT), 32'(1 << (s % 4)));
      START = 1; UNITS = 8'd10;
      step();
      START = 0;
      TANKFULL = 1;
      step();
      TANKFULL = 0;
      check($sformatf("t2_done%0d", s), 32'(DONE), 32'h1);
      step();
    end
    REQ = '0;
    step();
    // Last grant was lane 0; pointer = 0

    // Emergency stop with coincident tick
    REQ = 4'b0100;
    step();
    check("t3_grant", 32'(GRANT), 32'h4);
    START = 1; UNITS = 8'd5;
    step();
    START = 0;
    FLOW_TICK = 1;
    step();
    step();
    check("t3_cnt2", 32'(DELIVERED), 32'h2);
    EMERGENCY_STOP = 1;
    step();
    EMERGENCY_STOP = 0; FLOW_TICK = 0; REQ = '0;
    check("t3_cnt3", 32'(DELIVERED), 32'h3);
    check("t3_gas_off", 32'(DELIVERGAS), 32'h0);
    check("t3_done", 32'(DONE), 32'h1);
    step();
    check("t3_idle", 32'(state), 32'h0);

    // Zero-unit purchase: straight to CLOSE
    REQ = 4'b0001;
    step();
    check("t4_grant", 32'(GRANT), 32'h1);
    START = 1; UNITS = 8'd0;
    step();
    START = 0;
    check("t4_gas", 32'(DELIVERGAS), 32'h0);
    check("t4_close", 32'(state), 32'h3);
    check("t4_done", 32'(DONE), 32'h1);
    check("t4_deliv", 32'(DELIVERED), 32'h0);
    REQ = '0;
    step();

    // Granted lane withdraws in ARMED; pointer = 0 so lane 1 wins over lane 3
    REQ = 4'b1010;
    step();
    check("t5_grant", 32'(GRANT), 32'h2);
    REQ = 4'b1000;
    step();
    check("t5_idle", 32'(state), 32'h0);
    check("t5_nodone", 32'(DONE), 32'h0);
    check("t5_grant_clr", 32'(GRANT), 32'h0);
    step();
    check("t5_next", 32'(GRANT), 32'h8);
    REQ = '0;
    step();
    step();

    // Payment wait: timeout or indefinite hold
    REQ = 4'b0001;
    step();
    check("t6_grant", 32'(GRANT), 32'h1);
`ifdef PUMP_SCHED_TIMEOUT_EN
    repeat (15) step();
    check("t6_still_armed", 32'(state), 32'h1);
    step();
    check("t6_to_close", 32'(state), 32'h3);
    check("t6_done", 32'(DONE), 32'h1);
    check("t6_deliv", 32'(DELIVERED), 32'h0);
    REQ = '0;
    step();
`else
    repeat (120) step();
    check("t6_hold_grant", 32'(GRANT), 32'h1);
    check("t6_hold_state", 32'(state), 32'h1);
    check("t6_nodone", 32'(DONE), 32'h0);
`endif

    // Asynchronous reset mid-delivery
    REQ = 4'b0001;
    if (state == 2'b00) step();
    START = 1; UNITS = 8'd9;
    step();
    START = 0;
    check("t7_gas_on", 32'(DELIVERGAS), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("t7_gas_async", 32'(DELIVERGAS), 32'h0);
    check("t7_grant_async", 32'(GRANT), 32'h0);
    check("t7_done_async", 32'(DONE), 32'h0);
    reset = 1'b0; REQ = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
